iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Parametrised multi-cycle barrel-shift unit for the ALU datapath; generalises the 16-bit left shifter.
- Adds width/step parameters and five shift modes: LSL, LSR, ASR, ROL, ROR.
- Adds a real carry-out and a start/busy/done handshake.
- Shifts STEP bits per clock from a working register. The result register holds the previous result until the new operation completes.

Parameters:
- WIDTH, 16, operand/result width (>=2).
- AMT_W, 5, width of shift-amount input.
- STEP, 1, bits shifted per cycle; power of two, 1..WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only in IDLE
- a  in  WIDTH  operand
- amt  in  AMT_W  unsigned shift amount
- mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- s  out  WIDTH  registered result
- cout  out  1  registered carry-out (last bit shifted/rotated out)

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, s=0, cout=0. Working registers cleared.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: start=1 at edge E0 latches a, mode and eff (effective amount); goes to SHIFT with busy=1.
  - SHIFT: each edge shifts the working register by k=min(STEP, remaining), then remaining -= k. At the first edge with remaining==0, s and cout are loaded from the working register and carry; state returns to IDLE; busy=0; done=1 for exactly one cycle.
- Effective amount:
  - LSL/LSR/ASR: eff = min(amt, WIDTH), saturating.
  - ROL/ROR: eff = amt mod WIDTH.
  - Reserved modes: eff = 0, result = a.
- Latency: N = ceil(eff/STEP) step edges. done is high in the cycle after edge E0+N+1. For eff=0, done follows E1.
- Fill rules:
  - LSL fills LSBs with 0.
  - LSR fills MSBs with 0.
  - ASR fills MSBs with a[WIDTH-1].
  - Rotates wrap bits around.
- Carry-out (eff>=1):
  - LSL: a[WIDTH-eff]
  - LSR/ASR: a[eff-1]
  - ROL: result[0]
  - ROR: result[WIDTH-1]
  - eff=0: cout=0.
- Saturated LSL/LSR by WIDTH gives s=0, with cout=a[0] (LSL) or a[WIDTH-1] (LSR).
- ASR by WIDTH gives all bits = sign, with cout=sign.
- start while busy=1 is ignored; inputs are not re-latched.
- start in the same cycle as done=1 is legal, since state is IDLE. It is accepted at that edge, and done drops next cycle.
- a, amt and mode may change freely after E0 without affecting the operation.
- s/cout change only on a completion edge or on reset.
- Arithmetic: amt is unsigned. The remaining counter is wide enough for WIDTH. No overflow or wrap of the counter is permitted.

Test Plan:
1. WIDTH=16, STEP=1; LSL a=0x00F1 amt=4 -> s=0x0F10, cout=0. busy high for 5 cycles; done pulse after E5; s holds old value before done.
2. LSL a=0x8001 amt=1 -> s=0x0002, cout=1. Then LSL a=0x8001 amt=20 -> s=0x0000, cout=1, done after E17.
3. ASR a=0x8000 amt=3 -> s=0xF000, cout=0. LSR a=0x8000 amt=3 -> s=0x1000, cout=0. ASR a=0x8004 amt=3 -> s=0xF000, cout=1.
4. ROR a=0x0001 amt=17 -> eff=1, s=0x8000, cout=1. ROL a=0x8001 amt=16 -> s=0x8001, cout=0, done after E1. mode=110 -> s=a, cout=0.
5. Handshake and reset:
   - start LSL amt=8, then pulse start with different a at cycles 2-4 -> ignored; result matches the first operand.
   - Back-to-back start on the done cycle -> second operation accepted.
   - rst_n=0 mid-SHIFT -> next cycle busy=0, done=0, s=0, cout=0; no done pulse afterwards.
6. STEP=4: LSL a=0x1234 amt=6 -> N=2, s=0x8D00, cout=0, done after E3. ROR amt=5 with a=0x0011 -> s=0x8800, cout=1.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle barrel shifter: LSL/LSR/ASR/ROL/ROR, STEP bits per clock, with
// start/busy/done handshake and a registered carry-out of the last bit moved.
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  localparam logic [2:0] M_LSL = 3'd0;
  localparam logic [2:0] M_LSR = 3'd1;
  localparam logic [2:0] M_ASR = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        w_q, w_d;
  logic [WIDTH-1:0]        s_q, s_d;
  logic                    c_q, c_d;
  logic                    cout_q, cout_d;
  logic                    done_q, done_d;
  logic [2:0]              mode_q, mode_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]        k;
  logic [WIDTH-1:0]        rot;
  logic signed [WIDTH-1:0] w_sgn;

  // Shifts saturate at WIDTH; rotates reduce modulo WIDTH; reserved modes pass a through.
  function automatic logic [CNT_W-1:0] eff_amt(input logic [AMT_W-1:0] amt_v,
                                               input logic [2:0]       md);
    logic [31:0] av;
    av = 32'(amt_v);
    case (md)
      M_LSL, M_LSR, M_ASR: eff_amt = (av >= 32'(WIDTH)) ? WIDTH_C : CNT_W'(av);
      M_ROL, M_ROR:        eff_amt = CNT_W'(av % 32'(WIDTH));
      default:             eff_amt = '0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (rem_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == SHIFT);
    done = done_q;
    s    = s_q;
    cout = cout_q;
  end

  // Datapath next-state: latch on accept, step while remaining, publish on completion
  always_comb begin
    w_d    = w_q;
    s_d    = s_q;
    c_d    = c_q;
    cout_d = cout_q;
    mode_d = mode_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    k      = (rem_q > STEP_C) ? STEP_C : rem_q;
    rot    = '0;
    w_sgn  = w_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_d    = a;
          mode_d = mode;
          rem_d  = eff_amt(amt, mode);
          c_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (rem_q == '0) begin
          s_d    = w_q;
          cout_d = c_q;
          done_d = 1'b1;
        end else begin
          rem_d = rem_q - k;
          case (mode_q)
            M_LSL: begin
              w_d = w_q << k;
              c_d = |(w_q & (ONE << (WIDTH_C - k)));
            end
            M_LSR: begin
              w_d = w_q >> k;
              c_d = |(w_q & (ONE << (k - 1'b1)));
            end
            M_ASR: begin
              w_d = w_sgn >>> k;
              c_d = |(w_q & (ONE << (k - 1'b1)));
            end
            M_ROL: begin
              rot = (w_q << k) | (w_q >> (WIDTH_C - k));
              w_d = rot;
              c_d = rot[0];
            end
            M_ROR: begin
              rot = (w_q >> k) | (w_q << (WIDTH_C - k));
              w_d = rot;
              c_d = rot[WIDTH-1];
            end
            default: w_d = w_q;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q    <= '0;
      s_q    <= '0;
      c_q    <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= '0;
      rem_q  <= '0;
    end else begin
      w_q    <= w_d;
      s_q    <= s_d;
      c_q    <= c_d;
      cout_q <= cout_d;
      done_q <= done_d;
      mode_q <= mode_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: a STEP=1 and a STEP=4 instance share inputs.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [4:0]  amt = '0;
  logic [2:0]  mode = '0;
  logic        busy1, done1, cout1, busy4, done4, cout4;
  logic [15:0] s1, s4;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROL = 3'd3, ROR = 3'd4;

  typedef struct packed {
    logic [15:0] a;
    logic [4:0]  amt;
    logic [2:0]  md;
    logic [15:0] s;
    logic        c;
    int          edges;
  } vec_t;

  iter_shifter #(.WIDTH(16), .AMT_W(5), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .amt(amt), .mode(mode),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
  );

  iter_shifter #(.WIDTH(16), .AMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .amt(amt), .mode(mode),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait for done; returns the edge index (E0 = 0) after which done rose.
  task automatic op(input bit sel, input logic [15:0] av, input logic [4:0] amv,
                    input logic [2:0] mv, output int done_edge, output int busy_cnt,
                    output bit early);
    logic [15:0] s_before;
    @(negedge clk);
    a = av; amt = amv; mode = mv; start = 1'b1;
    s_before = sel ? s4 : s1;
    @(posedge clk); #1;
    start = 1'b0;
    done_edge = -1; busy_cnt = 0; early = 1'b0;
    for (int e = 0; e < 100; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if ((sel ? done4 : done1) === 1'b1) begin done_edge = e; break; end
      if ((sel ? busy4 : busy1) === 1'b1) busy_cnt++;
      if ((sel ? s4 : s1) !== s_before) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done1 got %b exp 0", done1); end
    n_chk++; if (s1 !== 16'h0000) begin n_fail++; $display("FAIL reset_s1 got %h exp 0000", s1); end
    n_chk++; if (cout1 !== 1'b0) begin n_fail++; $display("FAIL reset_cout1 got %b exp 0", cout1); end
    n_chk++; if ({busy4, done4, cout4, s4} !== 19'd0) begin
      n_fail++; $display("FAIL reset_dut4 got %b%b%b %h exp all zero", busy4, done4, cout4, s4);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lsl_basic();
    int de, bc; bit early;
    op(1'b0, 16'h00F1, 5'd4, LSL, de, bc, early);
    n_chk++; if (s1 !== 16'h0F10) begin n_fail++; $display("FAIL lsl4_s got %h exp 0F10", s1); end
    n_chk++; if (cout1 !== 1'b0) begin n_fail++; $display("FAIL lsl4_cout got %b exp 0", cout1); end
    n_chk++; if (de !== 5) begin n_fail++; $display("FAIL lsl4_latency got %0d exp 5", de); end
    n_chk++; if (bc !== 5) begin n_fail++; $display("FAIL lsl4_busy_cycles got %0d exp 5", bc); end
    n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL lsl4_s_hold got %b exp 0", early); end
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL lsl4_busy_at_done got %b exp 0", busy1); end
    @(posedge clk); #1;
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL lsl4_done_width got %b exp 0", done1); end
  endtask

  task automatic test_shift_table();
    vec_t v[7];
    int de, bc; bit early;
    v[0] = '{a:16'h8001, amt:5'd1,  md:LSL, s:16'h0002, c:1'b1, edges:2};
    v[1] = '{a:16'h8001, amt:5'd20, md:LSL, s:16'h0000, c:1'b1, edges:17};
    v[2] = '{a:16'h8000, amt:5'd3,  md:ASR, s:16'hF000, c:1'b0, edges:4};
    v[3] = '{a:16'h8000, amt:5'd3,  md:LSR, s:16'h1000, c:1'b0, edges:4};
    v[4] = '{a:16'h8004, amt:5'd3,  md:ASR, s:16'hF000, c:1'b1, edges:4};
    v[5] = '{a:16'h8000, amt:5'd31, md:ASR, s:16'hFFFF, c:1'b1, edges:17};
    v[6] = '{a:16'h8000, amt:5'd20, md:LSR, s:16'h0000, c:1'b1, edges:17};
    for (int i = 0; i < 7; i++) begin
      op(1'b0, v[i].a, v[i].amt, v[i].md, de, bc, early);
      n_chk++; if (s1 !== v[i].s) begin n_fail++; $display("FAIL shift[%0d]_s got %h exp %h", i, s1, v[i].s); end
      n_chk++; if (cout1 !== v[i].c) begin n_fail++; $display("FAIL shift[%0d]_cout got %b exp %b", i, cout1, v[i].c); end
      n_chk++; if (de !== v[i].edges) begin n_fail++; $display("FAIL shift[%0d]_latency got %0d exp %0d", i, de, v[i].edges); end
    end
  endtask

  task automatic test_rotate_reserved();
    vec_t v[4];
    int de, bc; bit early;
    v[0] = '{a:16'h0001, amt:5'd17, md:ROR,  s:16'h8000, c:1'b1, edges:2};
    v[1] = '{a:16'h8001, amt:5'd16, md:ROL,  s:16'h8001, c:1'b0, edges:1};
    v[2] = '{a:16'h1234, amt:5'd5,  md:3'd6, s:16'h1234, c:1'b0, edges:1};
    v[3] = '{a:16'h8001, amt:5'd1,  md:ROL,  s:16'h0003, c:1'b1, edges:2};
    for (int i = 0; i < 4; i++) begin
      op(1'b0, v[i].a, v[i].amt, v[i].md, de, bc, early);
      n_chk++; if (s1 !== v[i].s) begin n_fail++; $display("FAIL rot[%0d]_s got %h exp %h", i, s1, v[i].s); end
      n_chk++; if (cout1 !== v[i].c) begin n_fail++; $display("FAIL rot[%0d]_cout got %b exp %b", i, cout1, v[i].c); end
      n_chk++; if (de !== v[i].edges) begin n_fail++; $display("FAIL rot[%0d]_latency got %0d exp %0d", i, de, v[i].edges); end
    end
  endtask

  task automatic test_ignore_busy();
    int de;
    de = -1;
    @(negedge clk);
    a = 16'h00FF; amt = 5'd8; mode = LSL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e < 60; e++) begin
      @(negedge clk);
      if (e >= 2 && e <= 4) begin
        start = 1'b1; a = 16'hFFFF; amt = 5'd3; mode = ROR;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done1 === 1'b1) begin de = e; break; end
    end
    start = 1'b0;
    n_chk++; if (s1 !== 16'hFF00) begin n_fail++; $display("FAIL ignore_s got %h exp FF00", s1); end
    n_chk++; if (cout1 !== 1'b0) begin n_fail++; $display("FAIL ignore_cout got %b exp 0", cout1); end
    n_chk++; if (de !== 9) begin n_fail++; $display("FAIL ignore_latency got %0d exp 9", de); end
  endtask

  task automatic test_back_to_back();
    int de, bc; bit early;
    op(1'b0, 16'h00F1, 5'd4, LSL, de, bc, early);
    n_chk++; if (s1 !== 16'h0F10) begin n_fail++; $display("FAIL b2b_first_s got %h exp 0F10", s1); end
    @(negedge clk);
    n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL b2b_done_cycle got %b exp 1", done1); end
    a = 16'hF008; amt = 5'd4; mode = LSR; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop got %b exp 0", done1); end
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b exp 1", busy1); end
    de = -1;
    for (int e = 1; e < 60; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin de = e; break; end
    end
    n_chk++; if (s1 !== 16'h0F00) begin n_fail++; $display("FAIL b2b_second_s got %h exp 0F00", s1); end
    n_chk++; if (cout1 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_cout got %b exp 1", cout1); end
    n_chk++; if (de !== 5) begin n_fail++; $display("FAIL b2b_latency got %0d exp 5", de); end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    a = 16'h00FF; amt = 5'd8; mode = LSL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b exp 1", busy1); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy1); end
    n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b exp 0", done1); end
    n_chk++; if (s1 !== 16'h0000) begin n_fail++; $display("FAIL abort_s got %h exp 0000", s1); end
    n_chk++; if (cout1 !== 1'b0) begin n_fail++; $display("FAIL abort_cout got %b exp 0", cout1); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 || busy1 === 1'b1) seen++;
    end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_step4();
    int de, bc; bit early;
    op(1'b1, 16'h1234, 5'd6, LSL, de, bc, early);
    n_chk++; if (s4 !== 16'h8D00) begin n_fail++; $display("FAIL step4_lsl_s got %h exp 8D00", s4); end
    n_chk++; if (cout4 !== 1'b0) begin n_fail++; $display("FAIL step4_lsl_cout got %b exp 0", cout4); end
    n_chk++; if (de !== 3) begin n_fail++; $display("FAIL step4_lsl_latency got %0d exp 3", de); end
    n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL step4_lsl_s_hold got %b exp 0", early); end
    op(1'b1, 16'h0011, 5'd5, ROR, de, bc, early);
    n_chk++; if (s4 !== 16'h8800) begin n_fail++; $display("FAIL step4_ror_s got %h exp 8800", s4); end
    n_chk++; if (cout4 !== 1'b1) begin n_fail++; $display("FAIL step4_ror_cout got %b exp 1", cout4); end
    n_chk++; if (de !== 3) begin n_fail++; $display("FAIL step4_ror_latency got %0d exp 3", de); end
    op(1'b1, 16'h8001, 5'd20, LSL, de, bc, early);
    n_chk++; if ({s4, cout4} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL step4_lsl_sat got %h/%b exp 0000/1", s4, cout4); end
    n_chk++; if (de !== 5) begin n_fail++; $display("FAIL step4_sat_latency got %0d exp 5", de); end
  endtask

  initial begin
    test_reset();
    test_lsl_basic();
    test_shift_table();
    test_rotate_reserved();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_step4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
